// File: rtl/gd_pkg.sv
// Shared definitions for the gradient-descent iteration controller:
// termination codes, FSM state constants, Q24.8 limits and helpers.
package gd_pkg;

   // Termination cause reported on the status port.
   typedef enum logic [2:0] {
      STATUS_NONE      = 3'd0,
      STATUS_CONVERGED = 3'd1,
      STATUS_MAX_ITER  = 3'd2,
      STATUS_OVERFLOW  = 3'd3,
      STATUS_TIMEOUT   = 3'd4
   } status_t;

   // Controller state, kept as plain constants for legacy tool flows.
   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_ISSUE  = 3'd1;
   localparam state_t S_WAIT   = 3'd2;
   localparam state_t S_UPDATE = 3'd3;
   localparam state_t S_FIN    = 3'd4;

   // Q24.8 constants: 0x100 is 1.0, so 0x4 is 0.015625.
   localparam logic [31:0] Q24_ONE     = 32'h0000_0100;
   localparam logic [31:0] TOL_DEFAULT = 32'h0000_0004;

   // Saturation limits of a signed Q24.8 word.
   localparam logic [31:0] Q24_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] Q24_MIN = 32'h8000_0000;

   // Magnitude of a signed 32-bit word in 33 bits, so that the most
   // negative value maps to +2^31 instead of wrapping back to itself.
   function automatic logic [32:0] abs33(input logic [31:0] v);
      logic [32:0] ext;
      ext = {v[31], v};
      return v[31] ? (33'd0 - ext) : ext;
   endfunction

endpackage

// File: rtl/q24_sat_sub.sv
// Combinational signed Q24.8 subtract y = a - b with clamping to the
// representable range; sat_o flags that the result was clamped.
module q24_sat_sub
   import gd_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] y_o,
   output logic        sat_o
);

   logic [32:0] diff;

   // Exact difference in 33 bits, then clamp when bits 32 and 31 disagree.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // can leave it unassigned and infer a latch.
      y_o   = diff[31:0];
      sat_o = 1'b0;
      if (diff[32] != diff[31]) begin
         sat_o = 1'b1;
         y_o   = diff[32] ? Q24_MIN : Q24_MAX;
      end
   end

   assign diff = {a_i[31], a_i} - {b_i[31], b_i};

endmodule

// File: rtl/gd_iter_ctrl.sv
// Iteration controller for fixed-point gradient descent. Launches the
// central-difference gradient stage, applies x <- x - x_diff with
// saturation, and stops on convergence, iteration limit, overflow or
// a stalled gradient stage.
module gd_iter_ctrl
   import gd_pkg::*;
#(
   parameter int          MAX_ITER = 64,
   parameter int          ITER_W   = 8,
   parameter logic [31:0] TOL      = TOL_DEFAULT,
   parameter int          TIMEOUT  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       x_init,
   output logic              start_func,
   output logic [31:0]       x_cur,
   input  logic              func_done,
   input  logic [31:0]       x_diff_in,
   input  logic [63:0]       value_in,
   input  logic              ovf_in,
   output logic              busy,
   output logic              done,
   output logic [31:0]       x_final,
   output logic [63:0]       value_final,
   output logic [ITER_W-1:0] iter_count,
   output logic [2:0]        status,
   output logic              sat
);

   localparam int                TMO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);
   localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

   state_t            state_q,       state_d;
   logic [31:0]       x_cur_q,       x_cur_d;
   logic [31:0]       diff_q,        diff_d;
   logic              ovf_q,         ovf_d;
   logic [31:0]       x_final_q,     x_final_d;
   logic [63:0]       value_final_q, value_final_d;
   logic [ITER_W-1:0] iter_q,        iter_d;
   logic [2:0]        status_q,      status_d;
   logic              sat_q,         sat_d;
   logic [TMO_W-1:0]  tmo_q,         tmo_d;

   logic [31:0]       x_next;
   logic              x_next_sat;
   logic              step_small;

   // Candidate next point from the captured step.
   q24_sat_sub u_sub (
      .a_i   (x_cur_q),
      .b_i   (diff_q),
      .y_o   (x_next),
      .sat_o (x_next_sat)
   );

   assign step_small = (abs33(diff_q) <= {1'b0, TOL});

   // Next-state and datapath update for the whole controller.
   always_comb begin
      state_d       = state_q;
      x_cur_d       = x_cur_q;
      diff_d        = diff_q;
      ovf_d         = ovf_q;
      x_final_d     = x_final_q;
      value_final_d = value_final_q;
      iter_d        = iter_q;
      status_d      = status_q;
      sat_d         = sat_q;
      tmo_d         = tmo_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               x_cur_d  = x_init;
               iter_d   = '0;
               status_d = STATUS_NONE;
               sat_d    = 1'b0;
               tmo_d    = '0;
               state_d  = S_ISSUE;
            end
         end

         S_ISSUE: begin
            tmo_d   = '0;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (func_done) begin
               diff_d        = x_diff_in;
               value_final_d = value_in;
               ovf_d         = ovf_in;
               iter_d        = iter_q + 1'b1;
               state_d       = S_UPDATE;
            end else if (tmo_q == TMO_LAST) begin
               status_d  = STATUS_TIMEOUT;
               x_final_d = x_cur_q;
               state_d   = S_FIN;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         S_UPDATE: begin
            if (ovf_q) begin
               // The step is untrustworthy: report the point it was taken at.
               status_d  = STATUS_OVERFLOW;
               x_final_d = x_cur_q;
               state_d   = S_FIN;
            end else begin
               x_cur_d = x_next;
               if (x_next_sat) begin
                  sat_d = 1'b1;
               end
               if (step_small) begin
                  status_d  = STATUS_CONVERGED;
                  x_final_d = x_next;
                  state_d   = S_FIN;
               end else if (iter_q == ITER_LIMIT) begin
                  status_d  = STATUS_MAX_ITER;
                  x_final_d = x_next;
                  state_d   = S_FIN;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      if (rst) begin
         state_q       <= S_IDLE;
         x_cur_q       <= '0;
         diff_q        <= '0;
         ovf_q         <= 1'b0;
         x_final_q     <= '0;
         value_final_q <= '0;
         iter_q        <= '0;
         status_q      <= STATUS_NONE;
         sat_q         <= 1'b0;
         tmo_q         <= '0;
      end else begin
         state_q       <= state_d;
         x_cur_q       <= x_cur_d;
         diff_q        <= diff_d;
         ovf_q         <= ovf_d;
         x_final_q     <= x_final_d;
         value_final_q <= value_final_d;
         iter_q        <= iter_d;
         status_q      <= status_d;
         sat_q         <= sat_d;
         tmo_q         <= tmo_d;
      end
   end

   assign start_func  = (state_q == S_ISSUE);
   assign done        = (state_q == S_FIN);
   assign busy        = (state_q != S_IDLE);
   assign x_cur       = x_cur_q;
   assign x_final     = x_final_q;
   assign value_final = value_final_q;
   assign iter_count  = iter_q;
   assign status      = status_q;
   assign sat         = sat_q;

endmodule
